pipe_skid_reg: RTL and testbench

- Two-entry elastic pipeline register (main + skid) with valid/ready handshakes on both sides.
- Inserted between RISC-V core pipeline stages, e.g. IF->ID or ID->EX. Downstream stalls are absorbed without a combinational ready path from output to input.
- Adds synchronous flush for branch/jump redirects.
- Replaces plain enable-registers wherever backpressure must be cut for timing.

---
 rtl/pipe_skid_reg.sv | 101 ++++++++++
 tb/tb_pipe_skid_reg.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// Two-entry elastic pipeline register (main + skid) with valid/ready on both sides.
// All outputs come straight from registers, so out_ready never reaches in_ready combinationally.
module pipe_skid_reg #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data,
   output logic [1:0]   occupancy
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t       state, state_nxt;
   logic [N-1:0] main_q, skid_q;
   logic         in_fire, out_fire;
   logic         load_main_in, load_main_skid, load_skid;

   // The state encoding equals the entry count, so occupancy is the state itself.
   assign in_ready  = (state != FULL);
   assign out_valid = (state != EMPTY);
   assign out_data  = main_q;
   assign occupancy = state;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_nxt      = state;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush) begin
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (in_fire) begin
                  state_nxt    = ONE;
                  load_main_in = 1'b1;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  load_main_in = 1'b1;
               end else if (in_fire) begin
                  state_nxt = FULL;
                  load_skid = 1'b1;
               end else if (out_fire) begin
                  state_nxt = EMPTY;
               end
            end
            FULL: begin
               if (out_fire) begin
                  state_nxt      = ONE;
                  load_main_skid = 1'b1;
               end
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // Payload registers are reset too, so out_data reads zero after reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (load_main_in) begin
            main_q <= in_data;
         end else if (load_main_skid) begin
            main_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= in_data;
         end
      end
   end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: a FIFO-queue reference model tracks held entries,
// a negedge monitor compares every visible output against it.
module tb_pipe_skid_reg;

   localparam int N = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         flush = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [N-1:0] in_data = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [N-1:0] out_data;
   logic [1:0]   occupancy;

   pipe_skid_reg #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
      end
   endtask

   // Reference model: the list of entries the block should currently hold, oldest first.
   logic [N-1:0] model_q[$];
   bit           armed      = 0;
   bit           zero_known = 0;
   bit           stalled    = 0;
   logic [N-1:0] last_data  = '0;
   int           max_occ    = 0;

   always @(posedge clk) begin
      int  sz;
      bit  take_out, take_in;
      if (!rst) begin
         model_q.delete();
         zero_known = 1;
         stalled    = 0;
         armed      = 1;
      end else if (flush) begin
         model_q.delete();
         stalled = 0;
      end else begin
         sz       = model_q.size();
         take_out = (sz > 0) && out_ready;
         take_in  = in_valid && (sz < 2);
         stalled  = (sz > 0) && !out_ready;
         if (take_out) void'(model_q.pop_front());
         if (take_in) begin
            model_q.push_back(in_data);
            zero_known = 0;
         end
      end
      if (model_q.size() > max_occ) max_occ = model_q.size();
   end

   // Monitor: outputs are register-driven, so the negedge sees settled values.
   always @(negedge clk) begin
      if (armed) begin
         check("out_valid", 64'(out_valid), 64'(model_q.size() != 0));
         check("occupancy", 64'(occupancy), 64'(model_q.size()));
         check("in_ready", 64'(in_ready), 64'(model_q.size() != 2));
         if (model_q.size() != 0) check("out_data", 64'(out_data), 64'(model_q[0]));
         else if (zero_known) check("out_data_reset", 64'(out_data), 64'd0);
         if (stalled) check("stall_stable", 64'(out_data), 64'(last_data));
         last_data = out_data;
      end
   end

   task automatic step(input logic r, input logic fl, input logic iv,
                       input logic [N-1:0] d, input logic ordy);
      @(negedge clk);
      #1;
      rst       = r;
      flush     = fl;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
   endtask

   // Lets the next posedge happen, then samples after the following negedge.
   task automatic settle();
      @(negedge clk);
      #2;
   endtask

   initial begin
      // Reset held for two cycles, then idle.
      step(0, 0, 0, '0, 0);
      step(0, 0, 1, 32'hDEAD, 1);
      step(1, 0, 0, '0, 0);
      settle();
      check("idle_out_valid", 64'(out_valid), 64'd0);
      check("idle_out_data", 64'(out_data), 64'd0);
      check("idle_occupancy", 64'(occupancy), 64'd0);
      check("idle_in_ready", 64'(in_ready), 64'd1);

      // Streaming at full rate.
      step(1, 0, 1, 32'h11, 1);
      step(1, 0, 1, 32'h22, 1);
      step(1, 0, 1, 32'h33, 1);
      step(1, 0, 0, '0, 1);
      step(1, 0, 0, '0, 1);

      // Backpressure: fill, attempt a third push, then drain.
      step(1, 0, 1, 32'hA0, 0);
      step(1, 0, 1, 32'hB0, 0);
      step(1, 0, 1, 32'hC0, 0);
      settle();
      check("bp_occupancy", 64'(occupancy), 64'd2);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_data", 64'(out_data), 64'hA0);
      step(1, 0, 1, 32'hC0, 1);
      step(1, 0, 1, 32'hC0, 1);
      step(1, 0, 0, '0, 1);
      step(1, 0, 0, '0, 1);
      step(1, 0, 0, '0, 1);

      // Flush while full, with a simultaneous input that must be dropped.
      step(1, 0, 1, 32'h1, 0);
      step(1, 0, 1, 32'h2, 0);
      step(1, 1, 1, 32'h3, 0);
      step(1, 0, 0, '0, 1);
      #2;
      check("flush_occupancy", 64'(occupancy), 64'd0);
      check("flush_out_valid", 64'(out_valid), 64'd0);
      check("flush_in_ready", 64'(in_ready), 64'd1);

      // Reset while full.
      step(1, 0, 1, 32'h44, 0);
      step(1, 0, 1, 32'h55, 0);
      step(0, 0, 1, 32'h66, 1);
      step(1, 0, 0, '0, 0);
      #2;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_occupancy", 64'(occupancy), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);

      // Random traffic with occasional flush and reset.
      for (int i = 0; i < 10000; i++) begin
         step(($urandom_range(0, 999) != 0),
              ($urandom_range(0, 63) == 0),
              1'($urandom),
              N'($urandom),
              ($urandom_range(0, 3) != 0) ? 1'($urandom) : 1'b1);
      end
      step(1, 0, 0, '0, 1);
      step(1, 0, 0, '0, 1);
      step(1, 0, 0, '0, 1);
      settle();
      check("max_occupancy_le_2", 64'(max_occ <= 2), 64'd1);
      check("drained_occupancy", 64'(occupancy), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
